// File: rtl/split_eval_seq.sv
// split_eval_seq: collects up to NUM_VARS slot assignments over a valid/ready
// stream, then sweeps the slot bank one variable per cycle to evaluate one of
// four constraint modes and returns a held satisfied/error result.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      assignment beat handshake (ready only while collecting)
//   in_idx, in_data        target slot and value
//   in_last                final beat of the set; samples mode/threshold
//   mode, threshold        constraint select and mode-1 bound
//   res_valid/res_ready    result handshake
//   res_x, res_err         constraint satisfied, set/index error
module split_eval_seq #(
    parameter int unsigned NUM_VARS = 20,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned IDX_W    = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IDX_W-1:0]        in_idx,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_last,
    input  logic [1:0]              mode,
    input  logic [DATA_W+IDX_W-1:0] threshold,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    res_x,
    output logic                    res_err
);

    localparam int unsigned ACC_W   = DATA_W + IDX_W;
    localparam int unsigned SLOT_AW = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
    localparam int unsigned CNT_W   = $clog2(NUM_VARS + 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EVAL    = 2'd1,
        RESULT  = 2'd2
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   slot [NUM_VARS];
    logic [NUM_VARS-1:0] mask;
    logic                err_oor;
    logic [CNT_W-1:0]    cnt;
    logic [ACC_W-1:0]    acc;
    logic                par;
    logic                all_nz;
    logic [1:0]          mode_q;
    logic [ACC_W-1:0]    thr_q;

    logic                accept;
    logic                idx_ok;
    logic [SLOT_AW-1:0]  wr_addr;
    logic [SLOT_AW-1:0]  rd_addr;
    logic [DATA_W-1:0]   rd;

    assign accept  = in_valid & in_ready;
    assign idx_ok  = (32'(in_idx) < NUM_VARS);
    assign wr_addr = SLOT_AW'(in_idx);
    assign rd_addr = SLOT_AW'(cnt);

    // Current sweep operand; unmasked slots read as zero regardless of stale data.
    always_comb begin
        rd = '0;
        if ((32'(cnt) < NUM_VARS) && mask[rd_addr]) begin
            rd = slot[rd_addr];
        end
    end

    // Slot bank is deliberately not reset; the mask alone defines validity.
    always_ff @(posedge clk) begin
        if (accept && idx_ok) begin
            slot[wr_addr] <= in_data;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
            res_x     <= 1'b0;
            res_err   <= 1'b0;
            mask      <= '0;
            err_oor   <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            par       <= 1'b0;
            all_nz    <= 1'b1;
            mode_q    <= 2'd0;
            thr_q     <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (idx_ok) begin
                            mask[wr_addr] <= 1'b1;
                        end else begin
                            err_oor <= 1'b1;
                        end
                        if (in_last) begin
                            mode_q   <= mode;
                            thr_q    <= threshold;
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            state    <= EVAL;
                        end
                    end
                end
                EVAL: begin
                    // One extra step after the last slot folds the accumulators into the result.
                    if (cnt == CNT_W'(NUM_VARS)) begin
                        case (mode_q)
                            2'd0: res_x <= 1'b1;
                            2'd1: res_x <= (acc <= thr_q);
                            2'd2: res_x <= ~par;
                            2'd3: res_x <= all_nz;
                        endcase
                        res_err   <= err_oor | ~(&mask);
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end else begin
                        acc    <= acc + ACC_W'(rd);
                        par    <= par ^ (^rd);
                        all_nz <= all_nz & (rd != '0);
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        mask      <= '0;
                        err_oor   <= 1'b0;
                        acc       <= '0;
                        par       <= 1'b0;
                        all_nz    <= 1'b1;
                        cnt       <= '0;
                        state     <= COLLECT;
                    end
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= COLLECT;
                end
            endcase
        end
    end

endmodule
